// File: rtl/wb_master_pkg.sv
// Shared definitions for the Wishbone command master: FSM state encoding and
// response status codes.
package wb_master_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS  = 2'd1,
    RESP = 2'd2
  } wb_state_e;

  // Plain constants so the state register stays a simple logic vector.
  localparam logic [1:0] S_IDLE = IDLE;
  localparam logic [1:0] S_BUS  = BUS;
  localparam logic [1:0] S_RESP = RESP;

  localparam logic [1:0] ST_OK      = 2'b00;
  localparam logic [1:0] ST_ERR     = 2'b01;
  localparam logic [1:0] ST_TIMEOUT = 2'b10;

endpackage

// File: rtl/wb_timeout_ctr.sv
// Saturating cycle counter for the bus phase; expired is high once the
// current edge completes TIMEOUT_CYCLES cycles of CYC. Used under WB_TIMEOUT_EN.
module wb_timeout_ctr #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [W-1:0] LIMIT = W'(TIMEOUT_CYCLES - 1);
  localparam logic [W-1:0] MAX   = W'(TIMEOUT_CYCLES);

  logic [W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (enable && (cnt != MAX)) begin
      cnt <= cnt + 1'b1;
    end
  end

  // cnt holds the number of BUS edges already passed, so the edge that
  // sees cnt == TIMEOUT_CYCLES-1 closes the last allowed cycle.
  assign expired = (cnt >= LIMIT);

endmodule

// File: rtl/wb_cmd_master.sv
// Wishbone classic single-transfer initiator: one command in, one bus cycle,
// one response out. Define WB_TIMEOUT_EN to bound the bus phase (status 10).
module wb_cmd_master
  import wb_master_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_ni,
  input  logic        cmd_valid_i,
  output logic        cmd_ready_o,
  input  logic        cmd_we_i,
  input  logic [31:0] cmd_adr_i,
  input  logic [31:0] cmd_dat_i,
  input  logic [3:0]  cmd_sel_i,
  output logic        rsp_valid_o,
  input  logic        rsp_ready_i,
  output logic [31:0] rsp_dat_o,
  output logic [1:0]  rsp_status_o,
  output logic        wbm_cyc_o,
  output logic        wbm_stb_o,
  output logic        wbm_we_o,
  output logic [31:0] wbm_adr_o,
  output logic [31:0] wbm_dat_o,
  output logic [3:0]  wbm_sel_o,
  input  logic [31:0] wbm_dat_i,
  input  logic        wbm_ack_i,
  input  logic        wbm_err_i
);

  // Handshakes: a command transfers on the edge where cmd_valid_i & cmd_ready_o,
  // a response on the edge where rsp_valid_o & rsp_ready_i; the side holding
  // valid keeps its payload stable until that edge.

  logic [1:0] state;
  logic       accept;
  logic       timeout;

  assign accept = (state == S_IDLE) && cmd_valid_i && cmd_ready_o;

`ifdef WB_TIMEOUT_EN
  logic expired;

  wb_timeout_ctr #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout_ctr (
    .clk    (wb_clk_i),
    .rst_n  (wb_rst_ni),
    .clear  (accept),
    .enable (state == S_BUS),
    .expired(expired)
  );

  assign timeout = expired;
`else
  // Without the timeout the parameter only keeps the interface uniform.
  logic unused_timeout_cycles;
  assign unused_timeout_cycles = ^TIMEOUT_CYCLES;
  assign timeout = 1'b0;
`endif

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      state        <= S_IDLE;
      cmd_ready_o  <= 1'b0;
      rsp_valid_o  <= 1'b0;
      rsp_dat_o    <= '0;
      rsp_status_o <= ST_OK;
      wbm_cyc_o    <= 1'b0;
      wbm_stb_o    <= 1'b0;
      wbm_we_o     <= 1'b0;
      wbm_adr_o    <= '0;
      wbm_dat_o    <= '0;
      wbm_sel_o    <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          cmd_ready_o <= 1'b1;
          if (accept) begin
            cmd_ready_o <= 1'b0;
            wbm_cyc_o   <= 1'b1;
            wbm_stb_o   <= 1'b1;
            wbm_we_o    <= cmd_we_i;
            wbm_adr_o   <= cmd_adr_i;
            wbm_dat_o   <= cmd_dat_i;
            wbm_sel_o   <= cmd_sel_i;
            state       <= S_BUS;
          end
        end
        S_BUS: begin
          // ACK beats ERR, and both beat a timeout landing on the same edge.
          if (wbm_ack_i || wbm_err_i || timeout) begin
            wbm_cyc_o   <= 1'b0;
            wbm_stb_o   <= 1'b0;
            rsp_valid_o <= 1'b1;
            state       <= S_RESP;
            if (wbm_ack_i) begin
              rsp_dat_o    <= wbm_we_o ? 32'h0 : wbm_dat_i;
              rsp_status_o <= ST_OK;
            end else if (wbm_err_i) begin
              rsp_dat_o    <= 32'h0;
              rsp_status_o <= ST_ERR;
            end else begin
              rsp_dat_o    <= 32'h0;
              rsp_status_o <= ST_TIMEOUT;
            end
          end
        end
        S_RESP: begin
          if (rsp_ready_i) begin
            rsp_valid_o <= 1'b0;
            cmd_ready_o <= 1'b1;
            state       <= S_IDLE;
          end
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
